// File: rtl/ahb_switch_in.sv
// AHB-Lite slave for SW[7:0]: 2-flop sync + per-bit debounce, change-latched STATUS (W1C), IE mask, level IRQ.
// Zero wait states: HREADYOUT is constant 1, HRESP is constant OKAY, and read data is valid in the data phase.
module ahb_switch_in #(
   parameter int DB_CYCLES = 16
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [7:0]  SW,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic        IRQ
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic [7:0]    sw_s1_q, sw_s1_d;
   logic [7:0]    sw_s_q, sw_s_d;
   logic [7:0]    db_q, db_d;
   logic [CW-1:0] cnt_q [8];
   logic [CW-1:0] cnt_d [8];
   logic [7:0]    ie_q, ie_d;
   logic [7:0]    status_q, status_d;
   logic          wr_en_q, wr_en_d;
   logic          rd_en_q, rd_en_d;
   logic [2:0]    addr_q, addr_d;
   logic [7:0]    chg;
   logic [7:0]    wclr;
   logic          accept;
   logic          unused_ok;

   assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

   always_comb begin
      sw_s1_d = SW;
      sw_s_d  = sw_s1_q;
      db_d    = db_q;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_q[i];
         // Any return to the debounced level restarts the stability count.
         if (sw_s_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = sw_s_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      chg = db_d ^ db_q;

      ie_d = ie_q;
      wclr = '0;
      if (wr_en_q) begin
         case (addr_q)
            3'd2:    ie_d = HWDATA[7:0];
            3'd3:    wclr = HWDATA[7:0];
            default: ;
         endcase
      end
      // A new change event wins over a same-cycle clear.
      status_d = (status_q & ~wclr) | chg;

      accept  = HSEL & HTRANS[1] & HREADY;
      wr_en_d = accept & HWRITE;
      rd_en_d = accept & ~HWRITE;
      addr_d  = accept ? HADDR[4:2] : addr_q;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         sw_s1_q  <= '0;
         sw_s_q   <= '0;
         db_q     <= '0;
         ie_q     <= '0;
         status_q <= '0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      end else begin
         sw_s1_q  <= sw_s1_d;
         sw_s_q   <= sw_s_d;
         db_q     <= db_d;
         ie_q     <= ie_d;
         status_q <= status_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      HRDATA = '0;
      if (rd_en_q) begin
         case (addr_q)
            3'd0:    HRDATA = {24'b0, db_q};
            3'd1:    HRDATA = {24'b0, sw_s_q};
            3'd2:    HRDATA = {24'b0, ie_q};
            3'd3:    HRDATA = {24'b0, status_q};
            default: HRDATA = '0;
         endcase
      end
   end

   assign IRQ       = |(status_q & ie_q);
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_switch_in.sv
// Directed bench for ahb_switch_in: window-based debounce model checked every cycle, plus literal expectations.
module tb_ahb_switch_in;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  SW = 8'haa;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'b010;
   logic        HREADY = 1'b1;
   logic [31:0] HWDATA = '0;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        IRQ;

   int checks = 0;
   int errors = 0;

   ahb_switch_in #(.DB_CYCLES(16)) dut (
      .clk(clk), .RST(RST), .SW(SW), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: db flips once the last 16 synchronized samples all disagree with it.
   logic [7:0] m_s1, m_s, m_db, m_ie, m_st, m_new, m_wclr;
   logic [7:0] m_hist [16];
   logic       m_wr, m_rd, m_acc, m_all;
   logic [2:0] m_addr;
   bit         started = 0;

   always @(posedge clk) begin
      if (RST) begin
         m_s1 = '0; m_s = '0; m_db = '0; m_ie = '0; m_st = '0;
         m_wr = 0; m_rd = 0; m_addr = '0;
         for (int k = 0; k < 16; k++) m_hist[k] = '0;
         started = 1;
      end else begin
         for (int k = 15; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = m_s;
         m_new = m_db;
         for (int i = 0; i < 8; i++) begin
            m_all = 1;
            for (int k = 0; k < 16; k++) if (m_hist[k][i] == m_db[i]) m_all = 0;
            if (m_all) m_new[i] = ~m_db[i];
         end
         m_wclr = '0;
         if (m_wr && m_addr == 3'd3) m_wclr = HWDATA[7:0];
         if (m_wr && m_addr == 3'd2) m_ie = HWDATA[7:0];
         m_st = (m_st & ~m_wclr) | (m_new ^ m_db);
         m_db = m_new;
         m_s  = m_s1;
         m_s1 = SW;
         m_acc = HSEL && HTRANS[1] && HREADY;
         m_wr  = m_acc && HWRITE;
         m_rd  = m_acc && !HWRITE;
         if (m_acc) m_addr = HADDR[4:2];
      end
   end

   function automatic logic [31:0] m_hrdata();
      if (!m_rd) return 32'h0;
      case (m_addr)
         3'd0:    return {24'b0, m_db};
         3'd1:    return {24'b0, m_s};
         3'd2:    return {24'b0, m_ie};
         3'd3:    return {24'b0, m_st};
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (started) begin
         chk("model_hrdata", HRDATA, m_hrdata());
         chk("model_irq", {31'b0, IRQ}, {31'b0, |(m_st & m_ie)});
         chk("hreadyout", {31'b0, HREADYOUT}, 32'h1);
         chk("hresp", {31'b0, HRESP}, 32'h0);
      end
   end

   // One bus cycle: present an address phase and the write data for the previous one.
   task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic rdy = 1'b1);
      @(posedge clk);
      #1;
      HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = a; HWDATA = wd; HREADY = rdy;
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b1, 2'b10, 1'b1, a, 32'h0);
      step(1'b0, 2'b00, 1'b0, 32'h0, d);
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      step(1'b1, 2'b10, 1'b0, a, 32'h0);
      idle();
      @(negedge clk);
      chk(name, HRDATA, exp);
   endtask

   // Pulse reset while reading DATA every cycle; db must appear exactly 18 edges after the reset edge.
   task automatic do_reset(input logic [7:0] v);
      RST = 1'b1;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0; HREADY = 1'b1;
      @(posedge clk);
      #1 RST = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         chk("db_after_reset", HRDATA, (k >= 18) ? {24'b0, v} : 32'h0);
         if (k == 0) chk("irq_reset", {31'b0, IRQ}, 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      // Reset with SW=0xAA held.
      do_reset(8'haa);
      rd("raw_aa", 32'h4, 32'haa);
      rd("status_aa", 32'hc, 32'haa);
      chk("irq_ie0", {31'b0, IRQ}, 32'h0);

      // Glitch shorter than the debounce window.
      idle();
      SW[0] = 1'b1;
      repeat (10) idle();
      SW[0] = 1'b0;
      repeat (30) idle();
      rd("glitch_data", 32'h0, 32'haa);
      rd("glitch_status", 32'hc, 32'haa);

      // IRQ flow.
      wr(32'h8, 32'h1);
      wr(32'hc, 32'hff);
      rd("status_cleared", 32'hc, 32'h0);
      idle();
      SW[0] = 1'b1;
      repeat (17) idle();
      @(negedge clk);
      chk("irq_before", {31'b0, IRQ}, 32'h0);
      idle();
      @(negedge clk);
      chk("irq_rise", {31'b0, IRQ}, 32'h1);
      wr(32'hc, 32'h0);
      idle();
      @(negedge clk);
      chk("irq_w0_noeffect", {31'b0, IRQ}, 32'h1);
      rd("status_after_w0", 32'hc, 32'h1);
      wr(32'hc, 32'h1);
      @(negedge clk);
      chk("irq_during_w1c", {31'b0, IRQ}, 32'h1);
      idle();
      @(negedge clk);
      chk("irq_fall", {31'b0, IRQ}, 32'h0);
      rd("status_after_w1c", 32'hc, 32'h0);

      // W1C of STATUS[1] landing on the cycle db[1] toggles: set wins.
      idle();
      SW[1] = 1'b0;
      repeat (15) idle();
      step(1'b1, 2'b10, 1'b1, 32'hc, 32'h0);
      step(1'b0, 2'b00, 1'b0, 32'h0, 32'h2);
      idle();
      rd("status_set_wins", 32'hc, 32'h2);
      rd("data_a9", 32'h0, 32'ha9);

      // Bus behaviour.
      step(1'b1, 2'b10, 1'b1, 32'h8, 32'h0);
      step(1'b1, 2'b10, 1'b0, 32'h8, 32'h5a);
      idle();
      @(negedge clk);
      chk("b2b_ie", HRDATA, 32'h5a);
      rd("reserved_14", 32'h14, 32'h0);
      wr(32'h0, 32'hff);
      rd("data_write_ignored", 32'h0, 32'ha9);
      step(1'b1, 2'b00, 1'b1, 32'h8, 32'h0);
      step(1'b0, 2'b00, 1'b0, 32'h0, 32'hff);
      step(1'b1, 2'b01, 1'b1, 32'h8, 32'h0);
      step(1'b0, 2'b00, 1'b0, 32'h0, 32'hff);
      step(1'b1, 2'b10, 1'b1, 32'h8, 32'h0, 1'b0);
      step(1'b0, 2'b00, 1'b0, 32'h0, 32'hff);
      rd("ie_unchanged", 32'h8, 32'h5a);

      // Reset while cnt[3] is at 10.
      idle();
      SW[3] = 1'b0;
      repeat (12) idle();
      do_reset(8'ha1);
      rd("ie_after_reset", 32'h8, 32'h0);
      rd("status_after_reset", 32'hc, 32'ha1);
      rd("raw_after_reset", 32'h4, 32'ha1);

      repeat (2) idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_switch_in.md
# ahb_switch_in

AHB-Lite slave that brings the board slide switches `SW[7:0]` into the Cortex-M0 address map. Each switch bit is synchronized and debounced. The block exposes the debounced and raw values, latches per-bit change events, and raises a level interrupt to the NVIC. It sits on the SoC AHB-Lite bus as the receiving end of the switch lines that the SoC testbench and the board drive.

## Interface
- `DB_CYCLES`, 16: consecutive stable cycles a synchronized bit must hold before the debounced value follows it; legal range ≥2 (board build uses 500000).
- `clk`  in  1  system clock, all logic on rising edge.
- `RST`  in  1  reset; one clock, synchronous, active-high.
- `SW`  in  8  asynchronous switch inputs.
- `HSEL`  in  1  slave select.
- `HADDR`  in  32  address; only `HADDR[4:2]` decoded.
- `HTRANS`  in  2  transfer type; `HTRANS[1]`=1 means NONSEQ/SEQ.
- `HWRITE`  in  1  1=write.
- `HSIZE`  in  3  ignored; all accesses treated as word.
- `HREADY`  in  1  bus ready (previous data phase done).
- `HWDATA`  in  32  write data, valid in data phase.
- `HREADYOUT`  out  1  constant 1 (zero wait states).
- `HRESP`  out  1  constant 0 (OKAY).
- `HRDATA`  out  32  read data, valid in data phase.
- `IRQ`  out  1  `|(STATUS & IE)`.

## Operation
- Synchronizer: two flops per bit, `sw_s1 <= SW`, `sw_s <= sw_s1`; reset value 0.
- Debouncer, per bit i:
  - Keeps a counter `cnt[i]` of width `$clog2(DB_CYCLES)` and a debounced value `db[i]`.
  - If `sw_s[i]==db[i]`: `cnt[i]<=0`.
  - Else if `cnt[i]==DB_CYCLES-1`: `db[i]<=sw_s[i]` and `cnt[i]<=0`.
  - Else: `cnt[i]<=cnt[i]+1`.
  - Any glitch back to `db[i]` before the terminal count restarts the count from 0.
- Change event: `chg[i]` is true on the cycle `db[i]` toggles. Both rising and falling edges count.
- Register map, word offsets:
  - 0x00 DATA: RO, `{24'b0, db}`.
  - 0x04 RAW: RO, `{24'b0, sw_s}`.
  - 0x08 IE: RW, bits [7:0]; bits [31:8] read 0.
  - 0x0C STATUS: bits [7:0] set by `chg`; a write of 1 clears the bit (W1C); a write of 0 has no effect.
  - 0x10–0x1C: reserved; read 0, writes ignored.
- Writes to DATA and RAW are ignored.
- STATUS update: `STATUS <= (STATUS & ~wclr) | chg`. When a set and a clear hit the same bit in the same cycle, the set wins.
- AHB address phase is accepted when `HSEL & HTRANS[1] & HREADY`. On acceptance, register `wr_en=HWRITE`, `rd_en=~HWRITE`, and `addr_q=HADDR[4:2]`. When no transfer is accepted, `wr_en` and `rd_en` clear to 0.
- Data phase:
  - A write commits `HWDATA` to IE or STATUS at the end of the data-phase cycle.
  - A read drives `HRDATA` combinationally from `addr_q` and current register state.
  - When `rd_en=0`, `HRDATA` is 0.
- Back-to-back transfers are supported every cycle. A read of IE or STATUS that immediately follows a write to the same register returns the new value.

## Timing
- Reset values: `sw_s1`, `sw_s`, `db`, `cnt`, IE, STATUS, `wr_en`, `rd_en` and `addr_q` are all 0. Outputs during and after reset: `HRDATA`=0, `IRQ`=0, `HREADYOUT`=1, `HRESP`=0.
- Switch latency: if `SW[i]` changes just before edge E0 and stays stable, `sw_s[i]` updates at E1. `db[i]` updates at E1+`DB_CYCLES`, and STATUS[i] sets on that same edge.
- IRQ: combinational from the registers, so high in the cycle after STATUS/IE set. It falls in the cycle after the W1C data phase.
- Reset asserted mid-debounce or mid-transfer discards all state. The first post-reset `db` equals stable `SW` after 1+`DB_CYCLES` edges, and STATUS sets for each bit that became 1 (from reset value 0).
- Read latency: 0 wait states; data is valid in the cycle following the address phase.

## Test plan
- Reset with `SW`=8'haa, hold stable:
  - RAW reads 0xAA after 2 cycles.
  - DATA reads 0 until edge 1+16, then 0xAA.
  - STATUS=0xAA; IRQ stays 0 with IE=0.
- Glitch rejection: after settling, pulse `SW[0]` high for 10 cycles (<16), then release. DATA stays 0xAA and STATUS[0] does not set.
- IRQ flow:
  - Write IE=0x01, then W1C STATUS=0xFF; STATUS reads 0.
  - Toggle `SW[0]` and hold: IRQ rises 18 cycles later.
  - Write STATUS=0x01: IRQ falls the next cycle.
  - Write STATUS=0x00: no effect.
- Simultaneous set and clear: time a W1C of STATUS[1] data phase on the exact cycle `db[1]` toggles. STATUS[1] reads 1 afterwards.
- Bus: back-to-back write IE=0x5A then read IE returns 0x5A.
  - Read 0x14 returns 0; write to DATA is ignored.
  - Idle (`HTRANS`=0) with HSEL=1 causes no write.
  - `HREADYOUT`=1 and `HRESP`=0 throughout.
- Reset mid-operation: assert RST for 1 cycle while `cnt[3]`=10. All registers return to 0, and debounce restarts from 0.
